// File: rtl/axis_upsizer.sv
// axis_upsizer: packs narrow AXI4-Stream words into one wide word.
// Input words fill lanes from the bottom (lane 0 = first word). The number of
// words per output word is cfg_data[CNTR_WIDTH-1:0] + 1, capped at RATIO.
// The output stage is a single register. It accepts a new word in the same
// cycle that the old one drains, so a stream flows with no bubbles.
// M_AXIS_TDATA_WIDTH must be an integer multiple of S_AXIS_TDATA_WIDTH.
module axis_upsizer #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [15:0]                   cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int S          = S_AXIS_TDATA_WIDTH;
    localparam int M          = M_AXIS_TDATA_WIDTH;
    localparam int RATIO      = M / S;
    localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
    logic [M-1:0]          asm_q, asm_d;
    logic [M-1:0]          out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic                  last;
    logic                  s_hs;
    logic                  m_hs;
    logic [M-1:0]          asm_wr;
    logic [M-1:0]          word_full;
    logic                  cfg_unused;

    // Only the low CNTR_WIDTH bits of cfg_data select the word length.
    assign cfg_unused = ^cfg_data[15:CNTR_WIDTH];

    // The hardware cap at RATIO-1 also ends a word when cfg shrinks below cntr.
    assign last = (cntr_q == cfg_data[CNTR_WIDTH-1:0]) ||
                  (cntr_q == CNTR_WIDTH'(RATIO - 1));

    // Stall only when a last word would overwrite an output that cannot drain.
    assign s_axis_tready = !(last && out_valid_q && !m_axis_tready);

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = out_valid_q && m_axis_tready;

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;

    // Lane insertion: asm_wr writes only lane cntr. word_full also zeroes the
    // lanes above cntr, so a short word is padded with zeros in its upper lanes.
    always_comb begin
        asm_wr    = asm_q;
        word_full = asm_q;
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(cntr_q)) begin
                asm_wr[i*S +: S]    = s_axis_tdata;
                word_full[i*S +: S] = s_axis_tdata;
            end else if (i > int'(cntr_q)) begin
                word_full[i*S +: S] = '0;
            end
        end
    end

    // Next-state: pack on accept, load the output on the last word, drain on handshake.
    always_comb begin
        cntr_d      = cntr_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (s_hs && last) begin
            cntr_d      = '0;
            asm_d       = '0;
            out_data_d  = word_full;
            out_valid_d = 1'b1;
        end else begin
            if (s_hs) begin
                cntr_d = cntr_q + CNTR_WIDTH'(1);
                asm_d  = asm_wr;
            end
            if (m_hs) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cntr_q      <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cntr_q      <= cntr_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_axis_upsizer.sv
// Testbench for axis_upsizer with the default widths (32 -> 128).
// A per-cycle reference model tracks lanes, the word counter and the output
// flag. Completed words go into a scoreboard queue and are compared as they
// appear on the master side.
module tb_axis_upsizer;

    logic         aclk;
    logic         aresetn;
    logic [15:0]  cfg_data;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    axis_upsizer #(
        .S_AXIS_TDATA_WIDTH(32),
        .M_AXIS_TDATA_WIDTH(128)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state.
    logic [127:0] sb[$];
    logic [31:0]  lanes[4];
    int           m_cntr     = 0;
    bit           exp_valid  = 1'b0;
    bit           just_reset = 1'b1;
    logic [127:0] last_out   = '0;
    int           n_beats    = 0;

    // The model is evaluated on the falling edge. At that point the inputs and
    // outputs are the values the next rising edge will use.
    always @(negedge aclk) begin
        bit           m_last, exp_ready, acc, hs;
        logic [127:0] w;
        m_last    = (m_cntr == int'(cfg_data[1:0])) || (m_cntr == 3);
        exp_ready = !(m_last && exp_valid && !m_axis_tready);
        chk("s_tready", s_axis_tready, exp_ready);
        chk("m_tvalid", m_axis_tvalid, exp_valid);
        if (just_reset) begin
            chk("rst_tdata", m_axis_tdata, '0);
            just_reset = 1'b0;
        end
        if (exp_valid) begin
            chk("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) chk("m_tdata", m_axis_tdata, sb[0]);
        end
        hs  = exp_valid && m_axis_tready;
        acc = s_axis_tvalid && exp_ready;
        if (!aresetn) begin
            sb.delete();
            m_cntr     = 0;
            exp_valid  = 1'b0;
            just_reset = 1'b1;
            for (int j = 0; j < 4; j++) lanes[j] = '0;
        end else begin
            if (hs && sb.size() > 0) begin
                last_out = sb.pop_front();
                n_beats++;
            end
            if (acc) begin
                lanes[m_cntr] = s_axis_tdata;
                if (m_last) begin
                    w = '0;
                    for (int j = 0; j <= m_cntr; j++) w[j*32 +: 32] = lanes[j];
                    sb.push_back(w);
                    for (int j = 0; j < 4; j++) lanes[j] = '0;
                    m_cntr    = 0;
                    exp_valid = 1'b1;
                end else begin
                    m_cntr++;
                    if (hs) exp_valid = 1'b0;
                end
            end else if (hs) begin
                exp_valid = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        cyc(n);
    endtask

    initial begin
        int b0;
        aresetn       = 1'b0;
        cfg_data      = 16'd3;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cyc(2);
        aresetn = 1'b1;
        cyc(1);

        // Full packing.
        cfg_data = 16'd3;
        send(32'h11111111); send(32'h22222222); send(32'h33333333); send(32'h44444444);
        idle(3);
        chk("full_pack", last_out, 128'h44444444_33333333_22222222_11111111);

        // Partial packing; the third word starts a new word in lane 0.
        cfg_data = 16'd1;
        send(32'hA); send(32'hB);
        idle(3);
        chk("partial_pack", last_out, 128'h0000000B_0000000A);
        send(32'hC); send(32'hD);
        idle(3);
        chk("partial_lane0", last_out, 128'h0000000D_0000000C);

        // Backpressure: one word pending, three more accepted, the last word stalls.
        cfg_data      = 16'd3;
        m_axis_tready = 1'b0;
        send(32'h101); send(32'h102); send(32'h103); send(32'h104);
        send(32'h201); send(32'h202); send(32'h203);
        s_axis_tdata  = 32'h204;
        s_axis_tvalid = 1'b1;
        cyc(3);
        m_axis_tready = 1'b1;
        send(32'h204);
        idle(3);
        chk("bp_second", last_out, 128'h00000204_00000203_00000202_00000201);

        // Streaming: 40 words back to back give 10 output beats.
        b0 = n_beats;
        for (int i = 1; i <= 40; i++) send(i);
        idle(3);
        chk("stream_beats", n_beats - b0, 10);
        chk("stream_last", last_out, 128'h00000028_00000027_00000026_00000025);

        // Reset mid-word discards the partial word.
        send(32'hDEAD); send(32'hBEEF);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b0;
        cyc(1);
        aresetn = 1'b1;
        b0 = n_beats;
        send(32'h1); send(32'h2); send(32'h3); send(32'h4);
        idle(3);
        chk("rst_midword", last_out, 128'h00000004_00000003_00000002_00000001);
        chk("rst_beats", n_beats - b0, 1);

        // Configuration shrink while cntr is already past the new value.
        cfg_data = 16'd3;
        b0 = n_beats;
        send(32'h51); send(32'h52); send(32'h53);
        cfg_data = 16'd1;
        send(32'h54);
        idle(3);
        chk("shrink_word", last_out, 128'h00000054_00000053_00000052_00000051);
        send(32'h61); send(32'h62);
        idle(2);
        chk("shrink_pair1", last_out, 128'h00000062_00000061);
        send(32'h63); send(32'h64);
        idle(3);
        chk("shrink_pair2", last_out, 128'h00000064_00000063);
        chk("shrink_beats", n_beats - b0, 3);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
